// File: rtl/uart_tx_buf_if.sv
// uart_tx_buf bus bundle: Sobel byte input side
// and paced uart_tx output side with status.
interface uart_tx_buf_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      pi_data;
  logic            pi_flag;
  logic [7:0]      po_data;
  logic            po_flag;
  logic [ADDR_W:0] fifo_cnt;
  logic            overflow;

  modport master (
    output pi_data, pi_flag,
    input  po_data, po_flag, fifo_cnt, overflow
  );

  modport slave (
    input  pi_data, pi_flag,
    output po_data, po_flag, fifo_cnt, overflow
  );
endinterface

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO between Sobel stage and
// uart_tx, launches spaced one UART frame apart.
module uart_tx_buf #(
  parameter logic [25:0] UART_BPS = 26'd10_000_000,
  parameter logic [25:0] CLK_FREQ = 26'd50_000_000,
  parameter int          ADDR_W   = 4
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  uart_tx_buf_if.slave  bus
);

  localparam int BAUD_CNT  = int'(CLK_FREQ / UART_BPS);
  localparam int FRAME_CYC = BAUD_CNT * 11;
  localparam int FCW       = $clog2(FRAME_CYC);
  localparam int DEPTH     = 1 << ADDR_W;

  localparam logic [ADDR_W:0] FULL =
    (ADDR_W+1)'(DEPTH);
  localparam logic [FCW-1:0] FC_END =
    FCW'(FRAME_CYC - 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_d;
  logic            ovf_q;
  logic [7:0]      po_data_q;
  logic            po_flag_q;
  logic [FCW-1:0]  fcnt_q;
  logic            wr_en;
  logic            pop;

  // full is judged on the registered count only
  assign wr_en = bus.pi_flag && (cnt_q != FULL);
  assign pop   = (state_q == S_IDLE) &&
                 (cnt_q != '0);

  // occupancy: write and pop together cancel out
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)
      cnt_d = cnt_q + (ADDR_W+1)'(1);
    else if (!wr_en && pop)
      cnt_d = cnt_q - (ADDR_W+1)'(1);
  end

  // storage array, contents need no reset
  always_ff @(posedge sys_clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= bus.pi_data;
  end

  // pointers, count and sticky drop flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_en)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.pi_flag && (cnt_q == FULL))
        ovf_q <= 1'b1;
    end
  end

  // pacer: pop, strobe once, then hold off a frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      po_data_q <= 8'h00;
      po_flag_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      po_flag_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            po_data_q <= mem_q[rd_ptr_q];
            po_flag_q <= 1'b1;
            state_q   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          fcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (fcnt_q == FC_END)
            state_q <= S_IDLE;
          else
            fcnt_q <= fcnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.po_data  = po_data_q;
  assign bus.po_flag  = po_flag_q;
  assign bus.fifo_cnt = cnt_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed scoreboard bench for
// uart_tx_buf launch data, pacing and overflow.
module tb_uart_tx_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   maxcnt = 0;
  int   t0;
  int   t1;
  bit   prev_flag = 1'b0;
  logic [7:0] exp_q [$];
  int   lt [$];

  uart_tx_buf_if #(.ADDR_W(4)) bus ();

  uart_tx_buf #(
    .UART_BPS(26'd10_000_000),
    .CLK_FREQ(26'd50_000_000),
    .ADDR_W(4)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_run++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] d,
                        input bit keep);
    bus.pi_data = d;
    bus.pi_flag = 1'b1;
    if (keep) exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus.pi_flag = 1'b0;
  endtask

  task automatic wait_launches(input int n,
                               input int budget,
                               input string tag);
    int k = 0;
    while (lt.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, lt.size() >= n, 1);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_po_data"}, bus.po_data, 0);
    chk({tag, "_po_flag"}, bus.po_flag, 0);
    chk({tag, "_fifo_cnt"}, bus.fifo_cnt, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  // scoreboard: every launch must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(bus.fifo_cnt) > maxcnt)
        maxcnt = int'(bus.fifo_cnt);
      if (bus.po_flag) begin
        lt.push_back(cyc);
        chk("po_flag_width", prev_flag, 0);
        chk("launch_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("po_data", bus.po_data, exp_q.pop_front());
      end
      prev_flag = bus.po_flag;
    end else begin
      prev_flag = 1'b0;
    end
  end

  initial begin
    bus.pi_data = 8'h00;
    bus.pi_flag = 1'b0;

    // reset state
    tick(2);
    @(negedge clk);
    chk("rst_po_data", bus.po_data, 0);
    chk("rst_po_flag", bus.po_flag, 0);
    chk("rst_fifo_cnt", bus.fifo_cnt, 0);
    chk("rst_overflow", bus.overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);

    // single byte
    t0 = cyc;
    bus.pi_data = 8'hA5;
    bus.pi_flag = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    chk("single_cnt0", bus.fifo_cnt, 0);
    @(posedge clk);
    #1;
    bus.pi_flag = 1'b0;
    @(negedge clk);
    chk("single_cnt1", bus.fifo_cnt, 1);
    chk("single_flag_c1", bus.po_flag, 0);
    @(negedge clk);
    chk("single_cnt2", bus.fifo_cnt, 0);
    chk("single_flag_c2", bus.po_flag, 1);
    chk("single_data", bus.po_data, 8'hA5);
    @(negedge clk);
    chk("single_flag_c3", bus.po_flag, 0);
    chk("single_hold", bus.po_data, 8'hA5);
    @(posedge clk);
    #1;
    wait_launches(1, 10, "single_wait");
    if (lt.size() >= 1)
      chk("single_time", lt[0] - t0, 2);
    tick(60);

    // burst pacing
    lt.delete();
    maxcnt = 0;
    t0 = cyc;
    strobe(8'h01, 1'b1);
    strobe(8'h02, 1'b1);
    strobe(8'h03, 1'b1);
    wait_launches(3, 200, "burst_wait");
    if (lt.size() >= 3) begin
      chk("burst_t0", lt[0] - t0, 2);
      chk("burst_t1", lt[1] - t0, 57);
      chk("burst_t2", lt[2] - t0, 112);
    end
    chk("burst_peak", maxcnt, 2);
    chk("burst_drained", exp_q.size(), 0);
    tick(60);

    // overflow with 18 back-to-back strobes
    lt.delete();
    chk("ovf_pre", bus.overflow, 0);
    for (int i = 0; i < 17; i++)
      strobe(8'(i), 1'b1);
    bus.pi_data = 8'd17;
    bus.pi_flag = 1'b1;
    @(negedge clk);
    chk("ovf_before_drop", bus.overflow, 0);
    chk("ovf_full_cnt", bus.fifo_cnt, 16);
    @(posedge clk);
    #1;
    bus.pi_flag = 1'b0;
    @(negedge clk);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_cnt_after", bus.fifo_cnt, 16);
    @(posedge clk);
    #1;
    wait_launches(17, 17 * 55 + 60, "ovf_wait");
    if (lt.size() >= 17)
      chk("ovf_span", lt[16] - lt[0], 16 * 55);
    chk("ovf_drained", exp_q.size(), 0);
    tick(80);
    chk("ovf_count", lt.size(), 17);
    chk("ovf_sticky", bus.overflow, 1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("ovf_cleared", bus.overflow, 0);

    // full FIFO with simultaneous pop
    lt.delete();
    t0 = cyc;
    strobe(8'h40, 1'b1);
    for (int i = 0; i < 16; i++)
      strobe(8'h50 + 8'(i), 1'b1);
    tick(39);
    bus.pi_data = 8'hEE;
    bus.pi_flag = 1'b1;
    @(negedge clk);
    chk("fp_cnt_full", bus.fifo_cnt, 16);
    chk("fp_ovf_pre", bus.overflow, 0);
    @(posedge clk);
    #1;
    bus.pi_flag = 1'b0;
    @(negedge clk);
    chk("fp_ovf", bus.overflow, 1);
    chk("fp_cnt15", bus.fifo_cnt, 15);
    chk("fp_launch", bus.po_flag, 1);
    @(posedge clk);
    #1;
    wait_launches(17, 17 * 55 + 60, "fp_wait");
    if (lt.size() >= 2)
      chk("fp_t1", lt[1] - t0, 57);
    chk("fp_drained", exp_q.size(), 0);
    tick(80);
    chk("fp_count", lt.size(), 17);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // pointer wrap
    lt.delete();
    maxcnt = 0;
    for (int i = 0; i < 40; i++) begin
      strobe(8'(i), 1'b1);
      tick(59);
    end
    for (int i = 40; i < 60; i++) begin
      strobe(8'(i), 1'b1);
      tick(29);
    end
    wait_launches(60, 1500, "wrap_wait");
    chk("wrap_drained", exp_q.size(), 0);
    chk("wrap_ovf", bus.overflow, 0);
    chk("wrap_maxcnt", maxcnt <= 16, 1);
    tick(80);
    chk("wrap_count", lt.size(), 60);

    // reset mid-WAIT
    lt.delete();
    t0 = cyc;
    strobe(8'h11, 1'b1);
    for (int i = 0; i < 4; i++)
      strobe(8'h12 + 8'(i), 1'b0);
    tick(15);
    @(negedge clk);
    chk("mid_cnt", bus.fifo_cnt, 4);
    chk("mid_data", bus.po_data, 8'h11);
    @(posedge clk);
    #1;
    reset_pulse("mid_rst");
    tick(100);
    chk("mid_no_launch", lt.size(), 1);
    t1 = cyc;
    strobe(8'h77, 1'b1);
    wait_launches(2, 20, "mid_new_wait");
    if (lt.size() >= 2)
      chk("mid_new_time", lt[1] - t1, 2);
    chk("mid_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Byte buffer and pacer between the Sobel result stream and the UART transmitter. Accepts single-cycle byte strobes from `sobel_ctrl` (`po_data`/`po_flag`), stores them in a small FIFO, and re-issues them to `uart_tx` (`pi_data`/`pi_flag`). Consecutive bytes to `uart_tx` are spaced at least one full UART frame apart, because `uart_tx` has no busy output and would corrupt a frame if re-strobed mid-transmission.

## Interface

Parameters:

- `UART_BPS`, 26'd10_000_000, UART bit rate; must match `uart_tx`.
- `CLK_FREQ`, 26'd50_000_000, `sys_clk` frequency in Hz.
- `ADDR_W`, 4, FIFO address width; depth = 2**ADDR_W = 16.
- Derived localparam `BAUD_CNT` = CLK_FREQ/UART_BPS, which is 5 at defaults.
- Derived localparam `FRAME_CYC` = BAUD_CNT*11, which is 55 at defaults. This is 10 frame bits plus one guard bit.

Ports:

- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `pi_data`  in  8  byte from the Sobel stage.
- `pi_flag`  in  1  one-cycle write strobe for `pi_data`.
- `po_data`  out  8  byte to `uart_tx`; held stable between strobes.
- `po_flag`  out  1  one-cycle launch strobe to `uart_tx`.
- `fifo_cnt`  out  ADDR_W+1  number of bytes stored, excluding the byte in flight.
- `overflow`  out  1  sticky flag; set when a byte is dropped, cleared only by reset.

## Operation

- Storage:
  - Circular buffer of 2**ADDR_W bytes.
  - Write pointer and read pointer are ADDR_W bits wide and wrap modulo depth.
  - `fifo_cnt` is a registered occupancy count.
- Write:
  - Occurs on any cycle with `pi_flag`=1 and `fifo_cnt` != depth. Data goes to `mem[wr_ptr]` and `wr_ptr` increments.
  - If `pi_flag`=1 while `fifo_cnt` == depth, the byte is discarded and `overflow` is set to 1.
  - Full is judged on the registered `fifo_cnt`. A read in the same cycle does not rescue the write.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE: if `fifo_cnt` != 0, pop `mem[rd_ptr]` into the `po_data` register, increment `rd_ptr`, and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: `po_flag`=1 for this one cycle. Clear the frame counter and go to WAIT.
  - WAIT: the frame counter increments each cycle. When it reaches FRAME_CYC-3, go to IDLE.
- Pacing requirement: with the FIFO continuously non-empty, rising edges of `po_flag` are exactly FRAME_CYC cycles apart (55 at defaults).
- Simultaneous write and pop in one cycle:
  - The count is unchanged.
  - Both pointers advance.
  - No data is lost.
- No bypass path. A byte written into an empty FIFO must pass through storage.
- Ordering is strictly FIFO.
- `pi_flag` high for several consecutive cycles means one write per cycle.

## Timing

- Reset values, applied asynchronously:
  - `po_data`=8'h00, `po_flag`=0, `fifo_cnt`=0, `overflow`=0.
  - Both pointers at 0, frame counter at 0, state IDLE.
- Latency: `pi_flag` in cycle 0 into an empty, idle block gives:
  - `fifo_cnt`=1 in cycle 1.
  - Pop in cycle 1, with `fifo_cnt` back to 0 in cycle 2.
  - `po_flag`=1 with valid `po_data` in cycle 2.
- `po_data` updates in the same cycle `po_flag` rises. It holds its value until the next launch.
- A byte arriving while in WAIT is launched exactly FRAME_CYC cycles after the previous `po_flag`.
- Reset asserted mid-WAIT or mid-LAUNCH:
  - All contents and the in-flight state are discarded immediately.
  - After release, the first `po_flag` occurs no earlier than 2 cycles after the first new write.
- Buffer memory contents need no reset.

## Test plan

- **Single byte:** after reset, one strobe `pi_data`=8'hA5.
  - Required: `po_flag` pulse of exactly 1 cycle, 2 cycles later, with `po_data`=8'hA5.
  - Required: `fifo_cnt` sequence 0,1,0.
- **Burst pacing:** 3 back-to-back strobes 8'h01, 8'h02, 8'h03.
  - Required: three `po_flag` pulses, in order, at cycles 2, 57 and 112 relative to the first write.
  - Required: `fifo_cnt` peaks at 2.
- **Overflow:** 18 consecutive strobes with values 0..17.
  - Required: `overflow` rises on the cycle after the first dropped strobe and stays high.
  - Required: exactly 17 bytes are output (1 in flight + 16 stored), values 0..16. Value 17 is never output.
- **Full with simultaneous pop:** fill to 16, then strobe 8'hEE in the same cycle the FSM pops.
  - Required: 8'hEE is dropped, `overflow`=1, and `fifo_cnt` goes to 15.
- **Pointer wrap:** 40 bytes, 0..39, one strobe every 60 cycles, then 20 bytes at 1 per 30 cycles.
  - Required: all 60 bytes output in order, `overflow` stays 0, and `fifo_cnt` never exceeds 16.
- **Reset mid-operation:** 5 bytes queued, then `sys_rst_n` low for 3 cycles during WAIT.
  - Required: all outputs take their reset values asynchronously.
  - Required: no `po_flag` after release until a new write, which then launches 2 cycles after its strobe.
